uart_link_arbiter: RTL and testbench
====================================

# uart_link_arbiter

Shares the byte-wide serial communication port between two requesters (port 0: CPU I/O instructions; port 1: debug/loader). Arbitrates TX bytes, paces them to one per character time, and drives the one-shot send strobe. Retrieves each received byte, holds it for the port selected by `rx_sel`, and flags overrun. Sits between the CPU/loader and the serial communication block.

## Interface
- `BYTE_CYCLES`, 52083: clocks per transmitted character (10 bits at 9600 baud on 50 MHz); minimum 3.
- `CNT_W`, 16: pacing counter width; must satisfy 2^CNT_W > BYTE_CYCLES.

- `CLOCK_50`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1  port 0/1 has a TX byte.
- `req0_data` / `req1_data`  in  8  TX byte for port 0/1.
- `req0_ready` / `req1_ready`  out  1  byte accepted this cycle when valid & ready.
- `tx_data`  out  8  to the serial block `in`.
- `send_flag`  out  1  to the serial block `send_flag`.
- `data_available`  in  1  from the serial block.
- `rx_byte`  in  8  from the serial block `out`.
- `receive_flag`  out  1  to the serial block `receive_flag`.
- `rx_sel`  in  1  destination port for received bytes.
- `rx_valid0` / `rx_valid1`  out  1  held byte is available for port 0/1.
- `rx_data`  out  8  held received byte.
- `rx_ack`  in  1  consumer releases the held byte.
- `rx_overrun`  out  1  sticky: a byte was dropped.
- `overrun_clr`  in  1  clears `rx_overrun`.
- `tx_busy`  out  1  TX FSM not in IDLE.

## Operation
- TX FSM has three states.
  - IDLE: the arbiter grants one valid port. `readyN` is combinational and is high only in IDLE for the granted port. On acceptance, `tx_data` is registered from the granted data and the FSM moves to SEND.
  - SEND: `send_flag` = 1 for exactly one cycle, then GAP with the counter loaded to BYTE_CYCLES-3.
  - GAP: `send_flag` = 0. The counter decrements and the FSM goes to IDLE when it reaches 0.
- Round-robin arbitration. `last_grant` toggles only on acceptance.
  - Both ports valid: grant the port that is not `last_grant`.
  - One port valid: grant that port.
- `send_flag` always returns low for at least BYTE_CYCLES-1 cycles, so the downstream rising-edge one-shot fires once per byte.
- RX path:
  - `data_available` at cycle t registers `receive_flag`=1 for cycle t+1.
  - `rx_byte` is sampled at the end of t+1.
  - If the holding register is empty, or `rx_ack` is high in t+1, the byte is stored with `rx_sel` sampled at t+1.
  - The matching `rx_validN` rises in t+2 and stays high until the cycle after `rx_ack`.
- If the register is full and there is no `rx_ack`, the new byte is dropped and `rx_overrun` is set from t+2.
- Back-to-back `data_available` pulses pipeline: one capture per cycle, each subject to the full/empty rule.
- `rx_ack` while empty is ignored.
- `overrun_clr` and a new overrun in the same cycle: overrun wins (stays 1).

## Timing
- Reset values: all outputs 0, FSM = IDLE, counter = 0, `last_grant` = 1 (port 0 wins first), holding register empty.
- Reset asserted mid-SEND/GAP aborts immediately. `send_flag` and `tx_busy` drop asynchronously. A byte already strobed is not retracted.
- TX: accept at cycle t, `send_flag` at t+1, earliest next accept at t+BYTE_CYCLES. With continuous requests, accepts are exactly BYTE_CYCLES apart.
- RX latency: `data_available` at t gives `rx_validN` at t+2.
- `tx_busy` is high from t+1 through t+BYTE_CYCLES-1.
- `req*_data` is sampled only in the accept cycle. A valid that drops before a grant is simply not sent.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins when both ports are valid, and `last_grant` is not implemented.
- Not defined: round-robin as above.
- RX and pacing behaviour are identical in both builds.

## Structure
- Package `uart_arb_pkg`:
  - TX state enum (IDLE, SEND, GAP).
  - `BYTE_CYCLES_DEFAULT`.
  - `PORT0`/`PORT1` constants.
- Sub-module `uart_byte_pacer`: the loadable down-counter with a zero flag, taking load, load value and enable. It is instantiated once by the TX FSM.
- RX holding logic stays inline.

## Test plan
- BYTE_CYCLES=8, only port 0 valid with 0x41 then 0x42: accepts at t and t+8, `send_flag` one-cycle pulses at t+1 and t+9, `tx_data` 0x41 then 0x42.
- Both ports valid continuously (0x10 / 0x20) after reset: grants alternate 0x10, 0x20, 0x10, ... every 8 cycles. With `UART_ARB_FIXED_PRIO_EN`, only 0x10 is sent.
- `data_available` pulse, `rx_byte`=0x5A, `rx_sel`=1: `receive_flag` at t+1, `rx_valid1`=1 with `rx_data`=0x5A at t+2, `rx_valid0`=0. After `rx_ack`, `rx_valid1` is 0 the next cycle.
- Two bytes 0x01 and 0x02 without ack: `rx_data` stays 0x01 and `rx_overrun`=1. Applying `overrun_clr` clears it.
- Second byte with `rx_ack` in its capture cycle: no overrun, `rx_data`=0x02.
- `reset_n` low during GAP: `tx_busy`=0 and `send_flag`=0 immediately. After release, port 0 is granted first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the serial link arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // 10 bits at 9600 baud on a 50 MHz clock
    localparam int BYTE_CYCLES_DEFAULT = 52083;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/uart_byte_pacer.sv
// rtl/uart_byte_pacer.sv - loadable down-counter that paces one character time
module uart_byte_pacer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_link_arbiter.sv
// rtl/uart_link_arbiter.sv - two-port TX arbiter/pacer and RX holding register for the serial block
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first) instead of round-robin.
module uart_link_arbiter
    import uart_arb_pkg::*;
#(
    parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       send_flag,
    input  logic       data_available,
    input  logic [7:0] rx_byte,
    output logic       receive_flag,
    input  logic       rx_sel,
    output logic       rx_valid0,
    output logic       rx_valid1,
    output logic [7:0] rx_data,
    input  logic       rx_ack,
    output logic       rx_overrun,
    input  logic       overrun_clr,
    output logic       tx_busy
);

    // SEND and the final accept cycle account for the other 3 clocks of a character
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BYTE_CYCLES - 3);

    tx_state_e state;
    tx_state_e state_nxt;
    logic      grant0;
    logic      grant1;
    logic      accept;
    logic      pace_load;
    logic      pace_en;
    logic      pace_zero;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`else
    logic last_grant;

    assign grant0 = req0_valid & (~req1_valid | (last_grant == PORT1));
    assign grant1 = req1_valid & (~req0_valid | (last_grant == PORT0));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT1;
        end else if (accept) begin
            last_grant <= grant1 ? PORT1 : PORT0;
        end
    end
`endif

    assign accept = (state == IDLE) & (grant0 | grant1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx_data <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tx_data <= grant0 ? req0_data : req1_data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pace_load  = 1'b0;
        pace_en    = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        send_flag  = 1'b0;
        tx_busy    = 1'b1;
        case (state)
            IDLE: begin
                tx_busy    = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                send_flag = 1'b1;
                pace_load = 1'b1;
                state_nxt = GAP;
            end
            GAP: begin
                pace_en = 1'b1;
                if (pace_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    uart_byte_pacer #(
        .CNT_W (CNT_W)
    ) u_pacer (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .load     (pace_load),
        .load_val (GAP_LOAD),
        .en       (pace_en),
        .zero     (pace_zero)
    );

    // receive_flag marks the capture cycle; an ack in that same cycle frees room for the new byte
    logic rx_full;
    logic rx_dest;
    logic rx_capture;
    logic rx_drop;

    assign rx_capture = receive_flag & (~rx_full | rx_ack);
    assign rx_drop    = receive_flag & rx_full & ~rx_ack;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            receive_flag <= 1'b0;
            rx_full      <= 1'b0;
            rx_dest      <= PORT0;
            rx_data      <= 8'h00;
            rx_overrun   <= 1'b0;
        end else begin
            receive_flag <= data_available;
            if (rx_capture) begin
                rx_data <= rx_byte;
                rx_dest <= rx_sel;
                rx_full <= 1'b1;
            end else if (rx_ack) begin
                rx_full <= 1'b0;
            end
            if (rx_drop) begin
                rx_overrun <= 1'b1;
            end else if (overrun_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    assign rx_valid0 = rx_full & (rx_dest == PORT0);
    assign rx_valid1 = rx_full & (rx_dest == PORT1);

endmodule

// File: tb/tb_uart_link_arbiter.sv
// tb/tb_uart_link_arbiter.sv - self-checking bench for uart_link_arbiter with BYTE_CYCLES=8
module tb_uart_link_arbiter;

    localparam int BC = 8;

    logic       CLOCK_50;
    logic       reset_n;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       send_flag;
    logic       data_available;
    logic [7:0] rx_byte;
    logic       receive_flag;
    logic       rx_sel;
    logic       rx_valid0;
    logic       rx_valid1;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       rx_overrun;
    logic       overrun_clr;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -100;
    logic prev_sf = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    uart_link_arbiter #(.BYTE_CYCLES(BC), .CNT_W(16)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .tx_data        (tx_data),
        .send_flag      (send_flag),
        .data_available (data_available),
        .rx_byte        (rx_byte),
        .receive_flag   (receive_flag),
        .rx_sel         (rx_sel),
        .rx_valid0      (rx_valid0),
        .rx_valid1      (rx_valid1),
        .rx_data        (rx_data),
        .rx_ack         (rx_ack),
        .rx_overrun     (rx_overrun),
        .overrun_clr    (overrun_clr),
        .tx_busy        (tx_busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // TX scoreboard: every strobe must follow an accept by one cycle and match the next queued byte
    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) last_acc = cyc;
            if (send_flag) begin
                check("sf_latency", cyc - last_acc, 1);
                check("sf_width", {31'd0, prev_sf}, 0);
                if (tx_q.size() == 0) check("sf_unexpected", 1, 0);
                else check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            end
            prev_sf = send_flag;
        end
    end

    task automatic wait_acc(output int which, output int at);
        which = -1;
        for (int i = 0; i < 4 * BC; i++) begin
            @(negedge CLOCK_50);
            if (req0_valid && req0_ready) begin which = 0; break; end
            if (req1_valid && req1_ready) begin which = 1; break; end
        end
        at = cyc;
        if (which < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * BC; i++) begin
            @(negedge CLOCK_50);
            if (tx_q.size() == 0 && !tx_busy) break;
        end
        check("tx_drain", tx_q.size(), 0);
        check("tx_idle", {31'd0, tx_busy}, 0);
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        req0_valid = 0; req1_valid = 0; data_available = 0;
        rx_ack = 0; overrun_clr = 0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, t0, t1, busy, rdy_bad, exp_port, prev_t;
        reset_n = 0;
        req0_valid = 0; req0_data = 0; req1_valid = 0; req1_data = 0;
        data_available = 0; rx_byte = 0; rx_sel = 0; rx_ack = 0; overrun_clr = 0;
        repeat (2) @(negedge CLOCK_50);
        check("rst_send_flag", {31'd0, send_flag}, 0);
        check("rst_tx_busy", {31'd0, tx_busy}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_rx_valid", {30'd0, rx_valid1, rx_valid0}, 0);
        check("rst_rx_data", {24'd0, rx_data}, 0);
        check("rst_overrun", {31'd0, rx_overrun}, 0);
        check("rst_receive_flag", {31'd0, receive_flag}, 0);
        step();
        reset_n = 1;

        // port 0 only: 0x41 then 0x42, one character time apart
        step();
        req0_data = 8'h41; req0_valid = 1; tx_q.push_back(8'h41);
        wait_acc(w, t0);
        check("p0_port", w, 0);
        step();
        req0_data = 8'h42; tx_q.push_back(8'h42);
        busy = 0; rdy_bad = 0;
        for (int k = 1; k < BC; k++) begin
            @(negedge CLOCK_50);
            busy += int'(tx_busy);
            if (req0_ready) rdy_bad++;
        end
        check("busy_cycles", busy, BC - 1);
        check("ready_in_gap", rdy_bad, 0);
        wait_acc(w, t1);
        check("p0_spacing", t1 - t0, BC);
        step();
        req0_valid = 0;
        drain();

        // both ports valid continuously after reset
        do_reset();
        req0_data = 8'h10; req1_data = 8'h20;
        req0_valid = 1; req1_valid = 1;
        prev_t = 0;
        for (int n = 0; n < 4; n++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = n % 2;
`endif
            tx_q.push_back(exp_port == 1 ? 8'h20 : 8'h10);
            wait_acc(w, t1);
            check("arb_port", w, exp_port);
            if (n > 0) check("arb_spacing", t1 - prev_t, BC);
            prev_t = t1;
            step();
        end
        req0_valid = 0; req1_valid = 0;
        drain();

        // single received byte for port 1
        step();
        data_available = 1;
        step();
        data_available = 0; rx_byte = 8'h5A; rx_sel = 1; rx_q.push_back(8'h5A);
        @(negedge CLOCK_50);
        check("rx_receive_flag", {31'd0, receive_flag}, 1);
        step();
        rx_byte = 8'h00; rx_sel = 0;
        @(negedge CLOCK_50);
        check("rx_valid1", {31'd0, rx_valid1}, 1);
        check("rx_valid0", {31'd0, rx_valid0}, 0);
        check("rx_data_5a", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
        step();
        rx_ack = 1;
        @(negedge CLOCK_50);
        check("rx_valid1_ack_cycle", {31'd0, rx_valid1}, 1);
        step();
        rx_ack = 0;
        @(negedge CLOCK_50);
        check("rx_valid1_released", {31'd0, rx_valid1}, 0);

        // back-to-back bytes without ack: second dropped
        step();
        data_available = 1;
        step();
        rx_byte = 8'h01; rx_q.push_back(8'h01);
        step();
        data_available = 0; rx_byte = 8'h02;
        @(negedge CLOCK_50);
        check("ovr_not_yet", {31'd0, rx_overrun}, 0);
        check("ovr_valid0", {31'd0, rx_valid0}, 1);
        step();
        rx_byte = 8'h00;
        @(negedge CLOCK_50);
        check("ovr_set", {31'd0, rx_overrun}, 1);
        check("ovr_data_kept", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});

        // clear coinciding with a new overrun: overrun wins
        step();
        data_available = 1;
        step();
        data_available = 0; rx_byte = 8'h03; overrun_clr = 1;
        step();
        overrun_clr = 0;
        @(negedge CLOCK_50);
        check("ovr_wins_clr", {31'd0, rx_overrun}, 1);
        check("ovr_data_still", {24'd0, rx_data}, 8'h01);
        step();
        overrun_clr = 1;
        step();
        overrun_clr = 0;
        @(negedge CLOCK_50);
        check("ovr_cleared", {31'd0, rx_overrun}, 0);

        // ack in the capture cycle makes room for the new byte
        step();
        data_available = 1;
        step();
        data_available = 0; rx_byte = 8'h02; rx_ack = 1; rx_q.push_back(8'h02);
        step();
        rx_ack = 0;
        @(negedge CLOCK_50);
        check("ack_cap_no_ovr", {31'd0, rx_overrun}, 0);
        check("ack_cap_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
        check("ack_cap_valid0", {31'd0, rx_valid0}, 1);
        step();
        rx_ack = 1;
        step();
        rx_ack = 0;
        step();
        rx_ack = 1;
        step();
        rx_ack = 0;
        @(negedge CLOCK_50);
        check("ack_empty_valid", {30'd0, rx_valid1, rx_valid0}, 0);
        check("ack_empty_ovr", {31'd0, rx_overrun}, 0);

        // reset during GAP, then port 0 wins first
        step();
        req0_data = 8'h33; req0_valid = 1; tx_q.push_back(8'h33);
        wait_acc(w, t0);
        step();
        req0_valid = 0;
        repeat (3) @(negedge CLOCK_50);
        check("gap_busy_before", {31'd0, tx_busy}, 1);
        #2;
        reset_n = 0;
        #1;
        check("rst_gap_busy", {31'd0, tx_busy}, 0);
        check("rst_gap_send_flag", {31'd0, send_flag}, 0);
        step();
        step();
        reset_n = 1;
        req0_data = 8'h10; req1_data = 8'h20;
        req0_valid = 1; req1_valid = 1;
        tx_q.push_back(8'h10);
        wait_acc(w, t0);
        check("post_rst_port", w, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        drain();
        check("rx_q_empty", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
